// File: rtl/wc_tile_feeder.sv
// Winograd F(4,3) tile feeder: turns a serial sample stream into overlapping 6-sample tiles
// (stride 4, overlap 2), zero-padding the last tile of each row. Optional: WC_FEED_LEADPAD_EN.
`timescale 1ns/1ps
module wc_tile_feeder #(
  parameter int DW   = 10,
  parameter int TILE = 6,
  parameter int STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_last,
  output logic                 t_valid,
  input  logic                 t_ready,
  output logic [DW*TILE-1:0]   t_data,
  output logic                 t_last
);

  localparam int WW   = DW * TILE;
  localparam int KEEP = TILE - STEP;

  localparam logic [2:0] CNT_FULL = 3'(TILE);
  localparam logic [2:0] CNT_KEEP = 3'(KEEP);
`ifdef WC_FEED_LEADPAD_EN
  // The window is already zero at row start, so one leading zero sample is just cnt=1.
  localparam logic [2:0] CNT_START = 3'd1;
`else
  localparam logic [2:0] CNT_START = 3'd0;
`endif

  typedef enum logic [1:0] {
    FILL,
    PAD,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   win_q, win_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            last_q, last_d;

  logic [2:0]      cnt_inc;
  logic [DW-1:0]   shift_bits;
  logic [WW-1:0]   win_shift;

  // NOTE: combinational logic uses blocking assignments with every output defaulted first,
  // so no latch is inferred; the register block below uses non-blocking assignments only.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    cnt_inc    = cnt_q + 3'd1;
    shift_bits = (state_q == FILL) ? s_data : {DW{1'b0}};
    win_shift  = {win_q[WW-DW-1:0], shift_bits};

    case (state_q)
      FILL: begin
        if (s_valid) begin
          win_d = win_shift;
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_FULL) begin
            state_d = HOLD;
            last_d  = s_last;
          end else if (s_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        win_d = win_shift;
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_FULL) begin
          state_d = HOLD;
          last_d  = 1'b1;
        end
      end
      HOLD: begin
        if (t_ready) begin
          state_d = FILL;
          last_d  = 1'b0;
          if (last_q) begin
            win_d = '0;
            cnt_d = CNT_START;
          end else begin
            // The two newest samples stay in the low slots; four more shifts make them x0,x1.
            win_d = {{(WW - KEEP*DW){1'b0}}, win_q[KEEP*DW-1:0]};
            cnt_d = CNT_KEEP;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      win_q   <= '0;
      cnt_q   <= CNT_START;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign s_ready = (state_q == FILL);
  assign t_valid = (state_q == HOLD);
  assign t_data  = win_q;
  assign t_last  = last_q;

endmodule

// File: doc/wc_tile_feeder.md
Name: wc_tile_feeder

Overview:
- Upstream stage of the Winograd F(4,3) 1-D core.
- Takes a serial stream of signed samples, one per handshake, and builds overlapping 6-sample input tiles (stride 4, overlap 2) on the core's packed D-bus format.
- Zero-pads the final tile of each row and flags it.
- Decouples the sample source from the core with a valid/ready handshake on both sides.

Parameters:
- DW, 10, sample width in bits (two's complement)
- TILE, 6, samples per tile (fixed 6 for F(4,3); not a free parameter)
- STEP, 4, new samples per tile after the first (TILE-2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  feeder accepts a sample this cycle
- s_data  in  DW  input sample
- s_last  in  1  marks the last sample of a row
- t_valid  out  1  tile valid
- t_ready  in  1  downstream accepts the tile
- t_data  out  DW*TILE  tile; oldest sample x0 in bits [DW*6-1:DW*5], newest x5 in [DW-1:0]
- t_last  out  1  tile is the last of its row

Behaviour:
- Handshakes: a sample transfers when s_valid&&s_ready; a tile transfers when t_valid&&t_ready. t_data/t_last stay stable while t_valid&&!t_ready.
- Window: 6×DW shift register plus fill count cnt (0..6). An accepted sample shifts in at the LSB slot; older samples move toward the MSB; cnt increments.
- States: FILL, PAD, HOLD.
- FILL: s_ready=1, t_valid=0.
  - Accepted sample making cnt==6 → HOLD; t_last=s_last of that sample.
  - Accepted sample with s_last=1 and cnt<6 after the shift → PAD.
- PAD: s_ready=0. Each cycle shifts in one zero sample and increments cnt. When cnt reaches 6 → HOLD with t_last=1. Takes exactly 6-cnt cycles.
- HOLD: s_ready=0, t_valid=1.
  - On tile transfer with t_last=0: keep the newest 2 samples (x4,x5 become x0,x1), set cnt=2 → FILL.
  - On tile transfer with t_last=1: clear the window, cnt=0 → FILL (next row starts fresh).
- Latency: t_valid rises the cycle after the completing sample or the final pad cycle.
- Row of length N ≥ 6 yields ceil((N-2)/4) tiles. Row of length N < 6 yields one zero-padded tile.
- s_last on the sample that completes a tile: no padding; that tile carries t_last=1.
- s_valid while s_ready=0: ignored, no state change; the source must hold its data.
- No arithmetic; samples pass bit-exact.
- Reset (asynchronous, any state, including mid-row or mid-PAD): state=FILL, cnt=0, window=0, t_valid=0, t_last=0, t_data=0. s_ready=1 after reset deasserts.

Optional Feature:
- WC_FEED_LEADPAD_EN
- Defined: every row start (after reset and after each t_last transfer) preloads the window with one zero sample, cnt=1. This gives "same"-aligned 3-tap output; the first tile becomes [0,x0..x4].
- Undefined: rows start with cnt=0 ("valid" convolution alignment).

Test Plan:
- Stream 2,-10,3,4,-13,-18 with s_last on -18, t_ready=1 → one tile, t_data=60'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110, t_last=1, t_valid high one cycle after the 6th sample.
- Stream 10-sample row x0..x9 = 1..10, last on 10 → tile1 [1,2,3,4,5,6] t_last=0; tile2 [5,6,7,8,9,10] t_last=1; then cnt=0.
- Stream 8-sample row -19,-6,3,-9,-12,11,7,-1, last on -1 → tile1 [-19,-6,3,-9,-12,11]; tile2 [-12,11,7,-1,0,0] t_last=1 after exactly 2 PAD cycles.
- 3-sample row 5,6,7 → single tile [5,6,7,0,0,0] t_last=1 after 3 PAD cycles; with WC_FEED_LEADPAD_EN → [0,5,6,7,0,0].
- Backpressure: t_ready=0 for 5 cycles while a tile is held → t_data stable, s_ready=0, s_valid samples not consumed; on t_ready=1 the tile transfers and s_ready returns the next cycle.
- Assert rst mid-PAD and mid-HOLD → t_valid, t_data and t_last drop to 0 immediately (asynchronously); the following row 2,-10,3,4,-13,-18 reproduces the first scenario exactly.
